// File: rtl/if_id_buffer_pkg.sv
// Shared fetch/decode definitions: datapath width, the NOP bubble word and
// the buffer occupancy encoding. Decode imports this package as well.
package if_id_buffer_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  // An instruction pc is misaligned when either low bit is set.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/if_id_entry_reg.sv
// One {valid, pc, instr, misalign} storage slot of the fetch/decode buffer.
// Reset wins over clear, and clear wins over load.
module if_id_entry_reg
  import if_id_buffer_pkg::*;
#(
  parameter int W = XLEN,
  parameter logic [W-1:0] RST_INSTR = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d_pc,
  input  logic [W-1:0] d_instr,
  input  logic         d_misalign,
  output logic         q_valid,
  output logic [W-1:0] q_pc,
  output logic [W-1:0] q_instr,
  output logic         q_misalign
);

  logic         valid_r;
  logic [W-1:0] pc_r;
  logic [W-1:0] instr_r;
  logic         misalign_r;

  // Slot storage; clear keeps the pc so decode still sees the last address.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r    <= 1'b0;
      pc_r       <= {W{1'b0}};
      instr_r    <= RST_INSTR;
      misalign_r <= 1'b0;
    end else if (clear) begin
      valid_r    <= 1'b0;
      instr_r    <= RST_INSTR;
      misalign_r <= 1'b0;
    end else if (load) begin
      valid_r    <= 1'b1;
      pc_r       <= d_pc;
      instr_r    <= d_instr;
      misalign_r <= d_misalign;
    end
  end

  assign q_valid    = valid_r;
  assign q_pc       = pc_r;
  assign q_instr    = instr_r;
  assign q_misalign = misalign_r;

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode pipeline buffer: 2-entry skid buffer with valid/ready on both
// sides, jump flush to a NOP bubble, and a saturating decode-stall counter.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int XLEN = if_id_buffer_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = if_id_buffer_pkg::NOP_INSTR,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  output logic             out_misalign,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  buf_state_e       state_r;
  buf_state_e       state_nx_s;
  logic             in_ready_r;
  logic [CNT_W-1:0] stall_r;

  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             main_load_s;
  logic             main_clear_s;
  logic             main_from_skid_s;
  logic             skid_load_s;
  logic             skid_clear_s;

  logic [XLEN-1:0]  main_d_pc_s;
  logic [XLEN-1:0]  main_d_instr_s;
  logic             main_d_misalign_s;
  logic             in_misalign_s;

  logic             main_valid_s;
  logic [XLEN-1:0]  main_pc_s;
  logic [XLEN-1:0]  main_instr_s;
  logic             main_misalign_s;
  logic             skid_valid_s;
  logic [XLEN-1:0]  skid_pc_s;
  logic [XLEN-1:0]  skid_instr_s;
  logic             skid_misalign_s;

  assign in_xfer_s     = in_valid & in_ready_r;
  assign out_xfer_s    = main_valid_s & out_ready;
  assign in_misalign_s = pc_misaligned(in_pc[1:0]);

  // Main slot is refilled either from fetch or, when draining, from the skid slot.
  always_comb begin
    main_d_pc_s       = in_pc;
    main_d_instr_s    = in_instr;
    main_d_misalign_s = in_misalign_s;
    if (main_from_skid_s) begin
      main_d_pc_s       = skid_pc_s;
      main_d_instr_s    = skid_instr_s;
      main_d_misalign_s = skid_misalign_s;
    end else begin
      main_d_pc_s       = in_pc;
      main_d_instr_s    = in_instr;
      main_d_misalign_s = in_misalign_s;
    end
  end

  // Occupancy next-state and slot load/clear controls; flush overrides handshakes.
  always_comb begin
    state_nx_s       = state_r;
    main_load_s      = 1'b0;
    main_clear_s     = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clear_s     = 1'b0;
    if (flush) begin
      state_nx_s   = EMPTY;
      main_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_xfer_s) begin
            main_load_s = 1'b1;
            state_nx_s  = ONE;
          end else begin
            state_nx_s  = EMPTY;
          end
        end
        ONE: begin
          if (out_xfer_s && in_xfer_s) begin
            main_load_s  = 1'b1;
            state_nx_s   = ONE;
          end else if (out_xfer_s) begin
            main_clear_s = 1'b1;
            state_nx_s   = EMPTY;
          end else if (in_xfer_s) begin
            skid_load_s  = 1'b1;
            state_nx_s   = FULL;
          end else begin
            state_nx_s   = ONE;
          end
        end
        FULL: begin
          // A FULL state with an empty skid slot is inconsistent; drain to EMPTY.
          if (out_xfer_s && skid_valid_s) begin
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clear_s     = 1'b1;
            state_nx_s       = ONE;
          end else if (out_xfer_s) begin
            main_clear_s     = 1'b1;
            skid_clear_s     = 1'b1;
            state_nx_s       = EMPTY;
          end else begin
            state_nx_s       = FULL;
          end
        end
        default: begin
          main_clear_s = 1'b1;
          skid_clear_s = 1'b1;
          state_nx_s   = EMPTY;
        end
      endcase
    end
  end

  // Occupancy state and the registered fetch-side ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= (state_nx_s != FULL);
    end
  end

  // Saturating count of cycles where decode holds off a valid entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_r <= {CNT_W{1'b0}};
    end else if (main_valid_s && !out_ready && !flush && (stall_r != CNT_MAX)) begin
      stall_r <= stall_r + CNT_ONE;
    end
  end

  if_id_entry_reg #(
    .W         (XLEN),
    .RST_INSTR (NOP_INSTR)
  ) u_main (
    .clk        (clk),
    .reset      (reset),
    .load       (main_load_s),
    .clear      (main_clear_s),
    .d_pc       (main_d_pc_s),
    .d_instr    (main_d_instr_s),
    .d_misalign (main_d_misalign_s),
    .q_valid    (main_valid_s),
    .q_pc       (main_pc_s),
    .q_instr    (main_instr_s),
    .q_misalign (main_misalign_s)
  );

  if_id_entry_reg #(
    .W         (XLEN),
    .RST_INSTR ({XLEN{1'b0}})
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load_s),
    .clear      (skid_clear_s),
    .d_pc       (in_pc),
    .d_instr    (in_instr),
    .d_misalign (in_misalign_s),
    .q_valid    (skid_valid_s),
    .q_pc       (skid_pc_s),
    .q_instr    (skid_instr_s),
    .q_misalign (skid_misalign_s)
  );

  assign in_ready     = in_ready_r;
  assign out_valid    = main_valid_s;
  assign out_pc       = main_pc_s;
  assign out_instr    = main_instr_s;
  assign out_misalign = main_misalign_s;
  assign stall_cycles = stall_r;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer with a reference queue of expected entries;
// every cycle the presented entry, handshake flags and stall count are compared.
module tb_if_id_buffer;

  localparam int CW = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_misalign;
  logic          out_ready;
  logic [CW-1:0] stall_cycles;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  ent_t          sb[$];
  logic [31:0]   last_pc = 32'd0;
  logic [CW-1:0] stall_m = 4'd0;
  int            checks = 0;
  int            errors = 0;
  bit            chk_en = 1'b0;

  always #5 clk = ~clk;

  if_id_buffer #(
    .XLEN      (32),
    .NOP_INSTR (NOP),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_misalign (out_misalign),
    .out_ready    (out_ready),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the model, advance the model, take the edge.
  task automatic cycle();
    bit   ready_m;
    ent_t e;
    @(negedge clk);
    if (chk_en) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, (sb.size() != 0)});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (sb.size() < 2)});
      chk("stall_cycles", {28'b0, stall_cycles}, {28'b0, stall_m});
      if (sb.size() == 0) begin
        chk("bubble_instr", out_instr, NOP);
        chk("bubble_pc", out_pc, last_pc);
      end else begin
        chk("out_pc", out_pc, sb[0].pc);
        chk("out_instr", out_instr, sb[0].instr);
        chk("out_misalign", {31'b0, out_misalign}, {31'b0, sb[0].mis});
        last_pc = sb[0].pc;
      end
    end
    if (reset) begin
      sb.delete();
      last_pc = 32'd0;
      stall_m = 4'd0;
    end else begin
      ready_m = (sb.size() < 2);
      if ((sb.size() != 0) && !out_ready && !flush && (stall_m != 4'hF))
        stall_m = stall_m + 4'd1;
      if ((sb.size() != 0) && out_ready)
        e = sb.pop_front();
      if (flush) begin
        sb.delete();
      end else if (in_valid && ready_m) begin
        e.pc    = in_pc;
        e.instr = in_instr;
        e.mis   = (in_pc[1:0] != 2'b00);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    cycle();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_instr = 32'd0;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, NOP);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_stall", {28'b0, stall_cycles}, 32'd0);
    chk_en = 1'b1;
    cycle();

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(32'(4 * i), 32'hA0 + 32'(i));
    in_valid = 1'b0;
    cycle();
    cycle();

    // Backpressure: 0x10 in main, 0x14 in skid, 0x18 held by fetch
    out_ready = 1'b0;
    feed(32'h10, 32'hB0);
    feed(32'h14, 32'hB1);
    feed(32'h18, 32'hB2);
    cycle();
    chk("bp_out_pc", out_pc, 32'h10);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_stall", {28'b0, stall_cycles}, 32'd3);
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();

    // Flush while FULL, with a wrong-path word offered
    out_ready = 1'b0;
    feed(32'h40, 32'hC0);
    feed(32'h44, 32'hC1);
    flush = 1'b1;
    feed(32'h20, 32'hDEAD);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_out_instr", out_instr, NOP);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    chk("fl_out_pc", out_pc, 32'h40);
    out_ready = 1'b1;
    feed(32'h100, 32'hC2);
    in_valid = 1'b0;
    cycle();

    // Flush in the same cycle decode consumes the main entry
    feed(32'h300, 32'hC3);
    flush = 1'b1;
    feed(32'h304, 32'hBEEF);
    flush = 1'b0;
    in_valid = 1'b0;
    cycle();

    // Misaligned pcs, including one travelling through the skid slot
    feed(32'h102, 32'hD0);
    chk("mis_pc", out_pc, 32'h102);
    chk("mis_flag", {31'b0, out_misalign}, 32'd1);
    feed(32'h104, 32'hD1);
    chk("mis_clear", {31'b0, out_misalign}, 32'd0);
    out_ready = 1'b0;
    feed(32'h201, 32'hD2);
    feed(32'h206, 32'hD3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    // Counter saturation, then reset clears it
    out_ready = 1'b0;
    feed(32'h400, 32'hE0);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_stall", {28'b0, stall_cycles}, 32'hF);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst2_stall", {28'b0, stall_cycles}, 32'd0);
    chk("rst2_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst2_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst2_out_instr", out_instr, NOP);
    out_ready = 1'b1;
    feed(32'h500, 32'hF0);
    in_valid = 1'b0;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Fetch-to-decode pipeline buffer that sits directly downstream of the PC/instruction-fetch stage.
- Captures each fetched {pc, instruction} pair and presents it to the decode stage over a valid/ready handshake.
- A 2-entry skid buffer decouples decode stalls from fetch timing.
- Jump flush discards wrong-path entries and drives a NOP bubble to decode.

Parameters:
- XLEN, 32, width of pc and instruction paths.
- NOP_INSTR, 32'h00000013, instruction word driven on out_instr whenever out_valid=0 (addi x0,x0,0).
- CNT_W, 32, width of stall performance counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge only.
- reset  input  1  synchronous, active-high; 1 at a rising edge resets the block.
- flush  input  1  jump taken this cycle; wrong-path entries are discarded.
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}.
- in_pc  input  XLEN  pc of the fetched instruction.
- in_instr  input  XLEN  fetched instruction word.
- in_ready  output  1  buffer can accept a word this cycle.
- out_valid  output  1  decode-side entry valid.
- out_pc  output  XLEN  pc of the presented entry.
- out_instr  output  XLEN  instruction of the presented entry, or NOP_INSTR when out_valid=0.
- out_misalign  output  1  presented entry has out_pc[1:0] != 0.
- out_ready  input  1  decode accepts the entry this cycle.
- stall_cycles  output  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Storage:
  - main register drives all out_* ports directly; outputs are fully registered with no combinational input-to-output path.
  - skid register holds a second entry.
  - state encoding: EMPTY (no entries), ONE (main only), FULL (main+skid).
- Handshake events: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- in_ready = (state != FULL), registered, i.e. derived from current state only.
- Transitions when neither reset nor flush is asserted:
  - EMPTY: in_xfer -> load main, go to ONE; otherwise stay.
  - ONE, out_xfer & in_xfer -> main <= input, stay ONE.
  - ONE, out_xfer only -> go to EMPTY.
  - ONE, in_xfer only -> skid <= input, go to FULL.
  - ONE, neither -> hold.
  - FULL, out_xfer -> main <= skid, go to ONE. No input is accepted because in_ready=0.
  - FULL, no out_xfer -> hold all entries.
- Ordering: entries leave strictly in arrival order; no entry is duplicated or dropped except on flush or reset.
- flush=1 (priority over all handshakes, below reset):
  - next state EMPTY.
  - the in_valid word of that cycle is dropped.
  - an out_xfer of that cycle still counts as consumed by decode.
  - next cycle: out_valid=0, out_instr=NOP_INSTR, in_ready=1.
  - out_pc retains its last value.
- Reset values: state EMPTY, out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_misalign=0, in_ready=1, stall_cycles=0, skid contents 0.
- Reset asserted mid-transfer discards everything, same as flush, and also clears stall_cycles.
- Latency: a word accepted into an EMPTY buffer is visible on out_* one cycle later. Throughput is 1 word/cycle with out_ready held high.
- out_misalign is computed from the pc at capture time and travels with the entry, including through the skid register.
- stall_cycles increments by 1 on each cycle with out_valid & ~out_ready & ~flush, and holds at all-ones when it saturates.

Decomposition:
- Shared package (defines include), to be used by decode too:
  - NOP_INSTR constant.
  - XLEN.
  - state encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- Natural sub-module: if_id_entry_reg, a single {valid, pc, instr, misalign} register with load/clear; instantiated twice, once as main and once as skid.
- Control FSM and counter stay in the top.

Test Plan:
- Reset, then idle:
  - reset=1 for 2 cycles -> out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1, stall_cycles=0.
- Streaming:
  - in_valid=1 with pc 0x0,0x4,0x8,0xC and instr 0xA0..0xA3, out_ready=1 -> each pair appears on out_* exactly 1 cycle after it is accepted.
  - no gaps and no stalls; in_ready stays 1.
- Backpressure:
  - out_ready=0 while feeding pc 0x10,0x14,0x18 -> 0x10 held on out_pc and 0x14 captured in skid.
  - in_ready drops to 0 and 0x18 is held by fetch.
  - out_ready=1 -> out_pc sequence 0x10,0x14,0x18; stall_cycles equals the number of stalled cycles.
- Flush while FULL:
  - assert flush=1 with in_valid=1, pc 0x20 -> next cycle out_valid=0, out_instr=NOP_INSTR, in_ready=1.
  - 0x20 is never output; the next accepted pc 0x100 appears normally.
- Misaligned pc:
  - in_pc=0x102 -> out_misalign=1 while out_pc=0x102.
  - the following entry with pc 0x104 gives out_misalign=0.
- Counter saturation and reset:
  - CNT_W=4, stall 20 cycles -> stall_cycles=4'hF.
  - reset=1 for one cycle -> stall_cycles=0 and state EMPTY.
